mul_pipe_nxn: RTL and testbench

MUL_PIPE_NXN -- requirements
Module: mul_pipe_nxn

---
 rtl/mul_pipe_nxn.sv | 115 +++++++++++
 tb/tb_mul_pipe_nxn.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_nxn.sv
// Three-stage pipelined WIDTH x WIDTH multiplier (signed or unsigned per operation)
// built from four half-width partial products, with valid/ready flow control and flush.
module mul_pipe_nxn #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);

  localparam int H  = WIDTH / 2;
  localparam int PW = WIDTH + 2;
  localparam int OW = 2 * WIDTH;

  logic stall;
  logic accept;

  logic             s1_valid, s2_valid, s3_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_signed;
  logic [TAG_W-1:0] s1_tag, s2_tag;

  logic signed [PW-1:0] pp_hh_reg, pp_hl_reg, pp_lh_reg, pp_ll_reg;
  logic signed [PW-1:0] pp_hh_next, pp_hl_next, pp_lh_next, pp_ll_next;
  logic signed [H:0]    a_hi, a_lo, b_hi, b_lo;
  logic signed [OW-1:0] sum_next;

  assign stall     = s3_valid && !out_ready;
  assign in_ready  = !stall && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = s3_valid;

  // Valid bits: flush wins over stall, reset clears them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // S1: operand capture
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_a      <= in_a;
      s1_b      <= in_b;
      s1_signed <= in_signed;
      s1_tag    <= in_tag;
    end
  end

  // High halves carry the operand sign when signed; low halves are always unsigned.
  always_comb begin
    a_hi = {s1_signed & s1_a[WIDTH-1], s1_a[WIDTH-1:H]};
    b_hi = {s1_signed & s1_b[WIDTH-1], s1_b[WIDTH-1:H]};
    a_lo = {1'b0, s1_a[H-1:0]};
    b_lo = {1'b0, s1_b[H-1:0]};
    pp_hh_next = PW'(a_hi) * PW'(b_hi);
    pp_hl_next = PW'(a_hi) * PW'(b_lo);
    pp_lh_next = PW'(a_lo) * PW'(b_hi);
    pp_ll_next = PW'(a_lo) * PW'(b_lo);
  end

  // S2: partial products
  always_ff @(posedge clk) begin
    if (!stall) begin
      pp_hh_reg <= pp_hh_next;
      pp_hl_reg <= pp_hl_next;
      pp_lh_reg <= pp_lh_next;
      pp_ll_reg <= pp_ll_next;
      s2_tag    <= s1_tag;
    end
  end

  always_comb begin
    sum_next = (OW'(pp_hh_reg) <<< WIDTH)
             + (OW'(pp_hl_reg) <<< H)
             + (OW'(pp_lh_reg) <<< H)
             + OW'(pp_ll_reg);
  end

  // S3: summation; outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p    <= '0;
      out_tag  <= '0;
      out_zero <= 1'b0;
    end else if (!stall) begin
      out_p    <= sum_next;
      out_tag  <= s2_tag;
      out_zero <= s2_valid && (sum_next == '0);
    end
  end

endmodule

// File: tb/tb_mul_pipe_nxn.sv
// Directed testbench for mul_pipe_nxn (WIDTH=16, TAG_W=4): vector table plus
// hand-written stall, flush and asynchronous-reset sequences.
module tb_mul_pipe_nxn;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_p;
  logic [3:0]  out_tag;
  logic        out_zero;

  int n_vec = 0;
  int n_err = 0;

  mul_pipe_nxn #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [31:0] p;
    logic        z;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One isolated operation: accept, confirm 3-cycle latency, check the result.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    in_valid = 1'b1; in_signed = v.sgn; in_a = v.a; in_b = v.b; in_tag = v.tag;
    out_ready = 1'b1;
    #1 chk("vec_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("vec_lat1", out_valid, 0);
    @(negedge clk);
    chk("vec_lat2", out_valid, 0);
    @(negedge clk);
    chk("vec_valid", out_valid, 1);
    chk("vec_p", out_p, v.p);
    chk("vec_tag", out_tag, v.tag);
    chk("vec_zero", out_zero, v.z);
    $display("vec %0d: s=%0d a=%h b=%h -> p=%h tag=%h z=%0d", idx, v.sgn, v.a, v.b, out_p, out_tag, out_zero);
  endtask

  initial begin
    logic [31:0] exp_p[5];
    int idx, nrecv, seen;
    logic acc;

    tbl[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 4'h3, 32'hFFFE0001, 1'b0};
    tbl[1]  = '{1'b1, 16'hFFFF, 16'hFFFF, 4'h1, 32'h00000001, 1'b0};
    tbl[2]  = '{1'b1, 16'h8000, 16'h8000, 4'h2, 32'h40000000, 1'b0};
    tbl[3]  = '{1'b1, 16'h8000, 16'h0001, 4'h4, 32'hFFFF8000, 1'b0};
    tbl[4]  = '{1'b0, 16'h8000, 16'h0001, 4'h5, 32'h00008000, 1'b0};
    tbl[5]  = '{1'b0, 16'h1234, 16'h0000, 4'h6, 32'h00000000, 1'b1};
    tbl[6]  = '{1'b0, 16'h0003, 16'h0005, 4'h7, 32'h0000000F, 1'b0};
    tbl[7]  = '{1'b1, 16'hFFFE, 16'h0003, 4'h8, 32'hFFFFFFFA, 1'b0};
    tbl[8]  = '{1'b0, 16'h00FF, 16'h0100, 4'h9, 32'h0000FF00, 1'b0};
    tbl[9]  = '{1'b1, 16'h7FFF, 16'h7FFF, 4'hA, 32'h3FFF0001, 1'b0};
    tbl[10] = '{1'b1, 16'h7FFF, 16'h8000, 4'hB, 32'hC0008000, 1'b0};
    tbl[11] = '{1'b0, 16'h1234, 16'h5678, 4'hF, 32'h06260060, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");

    for (int i = 0; i < 12; i++) apply(tbl[i], i);

    // Back-to-back burst of 5 with consumer stalled in cycles 4..6.
    for (int i = 0; i < 5; i++) exp_p[i] = (32'h1000 + 32'(i)) * (32'h0010 + 32'(i));
    idx = 0; nrecv = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      if (idx < 5) begin
        in_valid = 1'b1; in_signed = 1'b0;
        in_a = 16'h1000 + 16'(idx); in_b = 16'h0010 + 16'(idx); in_tag = 4'(idx);
      end else in_valid = 1'b0;
      #1;
      if (c >= 4 && c <= 6) begin
        chk("b2b_stall_in_ready", in_ready, 0);
        chk("b2b_stall_valid", out_valid, 1);
      end
      if (out_valid) begin
        if (nrecv < 5) begin
          chk("b2b_p", out_p, exp_p[nrecv]);
          chk("b2b_tag", out_tag, 4'(nrecv));
          if (out_ready) begin
            $display("b2b cycle %0d: tag=%0d p=%h", c, out_tag, out_p);
            nrecv++;
          end
        end else begin
          chk("b2b_extra_output", 1, 0);
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    chk("b2b_count", 64'(nrecv), 5);

    // Flush with 3 operations in flight (consumer held off so none transfer).
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b0;
      in_a = 16'h0002; in_b = 16'h0002; in_tag = 4'(i);
      #1 chk("fl_accept", in_ready, 1);
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    #1 chk("fl_in_ready", in_ready, 0);
    chk("fl_three_in_flight", out_valid, 1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_cleared", out_valid, 0);
    $display("flush done");
    apply(tbl[11], 99);

    // Asynchronous reset with 2 operations in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h0011; in_b = 16'h0011; in_tag = 4'hC;
    @(negedge clk);
    in_tag = 4'hD;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ar_valid_before", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", out_valid, 0);
    chk("ar_p_zero", out_p, 0);
    chk("ar_tag_zero", out_tag, 0);
    chk("ar_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) chk("ar_in_ready_after", in_ready, 1);
      if (out_valid) seen++;
    end
    chk("ar_no_output", 64'(seen), 0);
    $display("async reset done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
